// File: rtl/evt_pkg.sv
// Shared definitions for the event ingress path.
// Holds the issue-FSM state encoding, the packed event record and the
// field positions of x and y inside the 16-bit event address.
package evt_pkg;

  localparam int unsigned EVT_DATA_WIDTH = 4;
  localparam int unsigned EVT_ADDR_WIDTH = 16;

  // Address is packed {x, y}.
  localparam int unsigned X_MSB = 15;
  localparam int unsigned X_LSB = 8;
  localparam int unsigned Y_MSB = 7;
  localparam int unsigned Y_LSB = 0;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDrop
  } issue_state_e;

  // Event record at the default widths; value sits above addr, matching the
  // concatenation order used for FIFO storage.
  typedef struct packed {
    logic [EVT_DATA_WIDTH-1:0] value;
    logic [EVT_ADDR_WIDTH-1:0] addr;
  } evt_t;

endpackage

// File: rtl/evt_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push, push_data   write request and data (ignored when full)
//   pop, pop_data     read request (ignored when empty) and head entry
//   count             occupancy, registered
//   full, empty       decoded from the registered count
module evt_sync_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage is not reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/event_ingress_fifo.sv
// Event ingress buffer between a sensor and a feature detector.
// Filters zero-valued (and, with EVT_BOUNDS_CHECK_EN defined, out-of-frame)
// events, buffers the rest and issues one event per detector request level.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   s_event_valid/value/addr/ready    sensor side, never stalled
//   event_req                         level request from the detector
//   out_event_valid_0/value_0/addr_0  one-cycle issue pulse, data held after
//   fifo_count                        buffer occupancy
//   drop_count                        saturating count of lost/filtered events
// Build option: EVT_BOUNDS_CHECK_EN enables the X_MAX/Y_MAX frame check.
module event_ingress_fifo
  import evt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 16,
  parameter logic [7:0]  X_MAX      = 8'd127,
  parameter logic [7:0]  Y_MAX      = 8'd127
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_event_valid,
  input  logic [DATA_WIDTH-1:0]   s_event_value,
  input  logic [ADDR_WIDTH-1:0]   s_event_addr,
  output logic                    s_event_ready,
  input  logic                    event_req,
  output logic                    out_event_valid_0,
  output logic [DATA_WIDTH-1:0]   out_event_value_0,
  output logic [ADDR_WIDTH-1:0]   out_event_addr_0,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [15:0]             drop_count
);

  localparam int unsigned EW = DATA_WIDTH + ADDR_WIDTH;

  issue_state_e          state_q, state_d;
  logic                  fifo_full, fifo_empty, pop;
  logic [EW-1:0]         head;
  logic                  in_bounds, accept, drop;
  logic [15:0]           drop_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic [ADDR_WIDTH-1:0] addr_q;

`ifdef EVT_BOUNDS_CHECK_EN
  assign in_bounds = (s_event_addr[X_MSB:X_LSB] <= X_MAX) &&
                     (s_event_addr[Y_MSB:Y_LSB] <= Y_MAX);
`else
  assign in_bounds = 1'b1;
`endif

  // Ready comes from the registered count only, so a pop in the same cycle
  // does not open a slot for the sensor.
  assign s_event_ready = !fifo_full;
  assign accept        = s_event_valid && s_event_ready && (s_event_value != '0) && in_bounds;
  assign drop          = s_event_valid && !accept;

  evt_sync_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_data({s_event_value, s_event_addr}),
    .pop      (pop),
    .pop_data (head),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // WAIT_DROP holds off further issues until the request level falls.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (event_req && !fifo_empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue:    state_d = StWaitDrop;
      StWaitDrop: if (!event_req) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      value_q <= '0;
      addr_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        value_q <= head[EW-1:ADDR_WIDTH];
        addr_q  <= head[ADDR_WIDTH-1:0];
      end
      if (drop && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
    end
  end

  assign out_event_valid_0 = (state_q == StIssue);
  assign out_event_value_0 = value_q;
  assign out_event_addr_0  = addr_q;
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_event_ingress_fifo.sv
module tb_event_ingress_fifo;
  import evt_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_event_valid = 1'b0;
  logic [3:0]    s_event_value = '0;
  logic [15:0]   s_event_addr = '0;
  logic          s_event_ready;
  logic          event_req = 1'b0;
  logic          out_event_valid_0;
  logic [3:0]    out_event_value_0;
  logic [15:0]   out_event_addr_0;
  logic [CW-1:0] fifo_count;
  logic [15:0]   drop_count;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   pulses = 0;
  evt_t sb[$];

  always #5 clk = ~clk;

  event_ingress_fifo #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(16),
    .DEPTH     (DEPTH),
    .X_MAX     (8'd127),
    .Y_MAX     (8'd127)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_event_valid    (s_event_valid),
    .s_event_value    (s_event_value),
    .s_event_addr     (s_event_addr),
    .s_event_ready    (s_event_ready),
    .event_req        (event_req),
    .out_event_valid_0(out_event_valid_0),
    .out_event_value_0(out_event_value_0),
    .out_event_addr_0 (out_event_addr_0),
    .fifo_count       (fifo_count),
    .drop_count       (drop_count)
  );

  // Scoreboard: every issue pulse must match the oldest expected event.
  always @(negedge clk) begin
    evt_t got, exp;
    if (rst_n && out_event_valid_0) begin
      pulses++;
      tests_run++;
      got.value = out_event_value_0;
      got.addr  = out_event_addr_0;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_pulse got %h expected none", got);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL pulse_order got %h expected %h", got, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_event_valid = 1'b0;
    event_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic push_ev(input logic [3:0] value, input logic [15:0] addr, input bit acc);
    evt_t e;
    s_event_valid = 1'b1;
    s_event_value = value;
    s_event_addr  = addr;
    if (acc) begin
      e.value = value;
      e.addr  = addr;
      sb.push_back(e);
    end
    tick();
    s_event_valid = 1'b0;
  endtask

  task automatic wait_pulse(input string name);
    int start = pulses;
    for (int i = 0; i < 8; i++) begin
      if (pulses != start) break;
      tick();
    end
    tests_run++;
    if (pulses == start) begin
      tests_failed++;
      $display("FAIL %s_timeout got 0 pulses expected 1", name);
    end
  endtask

  // One request-level toggle: issue one event, then release.
  task automatic request_one(input string name);
    event_req = 1'b1;
    wait_pulse(name);
    event_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_val("reset_valid", 32'(out_event_valid_0), 0);
    check_val("reset_value", 32'(out_event_value_0), 0);
    check_val("reset_addr", 32'(out_event_addr_0), 0);
    check_val("reset_count", 32'(fifo_count), 0);
    check_val("reset_drop", 32'(drop_count), 0);
    check_val("reset_ready", 32'(s_event_ready), 1);
  endtask

  task automatic test_latency();
    do_reset();
    event_req = 1'b1;
    push_ev(4'hF, 16'h3030, 1'b1);
    check_val("lat_n_valid", 32'(out_event_valid_0), 0);
    check_val("lat_n_count", 32'(fifo_count), 1);
    tick();
    check_val("lat_n1_valid", 32'(out_event_valid_0), 1);
    check_val("lat_n1_value", 32'(out_event_value_0), 32'hF);
    check_val("lat_n1_addr", 32'(out_event_addr_0), 32'h3030);
    tick();
    check_val("lat_n2_valid", 32'(out_event_valid_0), 0);
    check_val("lat_hold_addr", 32'(out_event_addr_0), 32'h3030);
    tick();
    check_val("lat_single", 32'(pulses), 1);
    event_req = 1'b0;
    tick();
  endtask

  task automatic test_toggle();
    int start;
    do_reset();
    push_ev(4'h1, 16'h0102, 1'b1);
    push_ev(4'h2, 16'h0304, 1'b1);
    push_ev(4'h3, 16'h0506, 1'b1);
    start = pulses;
    for (int i = 0; i < 3; i++) request_one("toggle");
    check_val("toggle_pulses", 32'(pulses - start), 3);
    check_val("toggle_drained", 32'(sb.size()), 0);
    push_ev(4'h4, 16'h0708, 1'b1);
    push_ev(4'h5, 16'h090A, 1'b1);
    start = pulses;
    event_req = 1'b1;
    repeat (6) tick();
    check_val("held_one_pulse", 32'(pulses - start), 1);
    check_val("held_count", 32'(fifo_count), 1);
    event_req = 1'b0;
    tick();
    tick();
    request_one("held_drain");
    check_val("held_drained", 32'(sb.size()), 0);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      check_val("ovf_ready", 32'(s_event_ready), (i < int'(DEPTH)) ? 1 : 0);
      push_ev(4'((i % 15) + 1), 16'(i * 257), i < int'(DEPTH));
    end
    check_val("ovf_count", 32'(fifo_count), DEPTH);
    check_val("ovf_drop", 32'(drop_count), 2);
    check_val("ovf_ready_low", 32'(s_event_ready), 0);
    for (int i = 0; i < int'(DEPTH); i++) request_one("ovf_drain");
    check_val("ovf_drained_count", 32'(fifo_count), 0);
    check_val("ovf_drained_sb", 32'(sb.size()), 0);
  endtask

  task automatic test_zero();
    int start;
    do_reset();
    push_ev(4'h0, 16'h1111, 1'b0);
    check_val("zero_count", 32'(fifo_count), 0);
    check_val("zero_drop", 32'(drop_count), 1);
    start = pulses;
    event_req = 1'b1;
    repeat (4) tick();
    event_req = 1'b0;
    check_val("zero_no_pulse", 32'(pulses - start), 0);
  endtask

  task automatic test_bounds();
    do_reset();
`ifdef EVT_BOUNDS_CHECK_EN
    push_ev(4'h5, 16'hC83A, 1'b0);
    check_val("bounds_drop", 32'(drop_count), 1);
    check_val("bounds_count", 32'(fifo_count), 0);
`else
    push_ev(4'h5, 16'hC83A, 1'b1);
    check_val("bounds_drop", 32'(drop_count), 0);
    check_val("bounds_count", 32'(fifo_count), 1);
    request_one("bounds_issue");
    check_val("bounds_addr", 32'(out_event_addr_0), 32'hC83A);
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_ev(4'h6, 16'h1020, 1'b1);
    push_ev(4'h7, 16'h3040, 1'b1);
    event_req = 1'b1;
    push_ev(4'h8, 16'h5060, 1'b1);
    check_val("b2b_count", 32'(fifo_count), 2);
    event_req = 1'b0;
    tick();
    tick();
    request_one("b2b_drain1");
    request_one("b2b_drain2");
    check_val("b2b_drained", 32'(sb.size()), 0);
  endtask

  task automatic test_mid_reset();
    int start;
    do_reset();
    for (int i = 0; i < 6; i++) push_ev(4'(i + 1), 16'(16'h0A00 + i), 1'b1);
    event_req = 1'b1;
    for (int i = 0; i < 8 && !out_event_valid_0; i++) tick();
    check_val("mid_in_issue", 32'(out_event_valid_0), 1);
    check_val("mid_count5", 32'(fifo_count), 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    check_val("mid_valid", 32'(out_event_valid_0), 0);
    check_val("mid_value", 32'(out_event_value_0), 0);
    check_val("mid_addr", 32'(out_event_addr_0), 0);
    check_val("mid_count", 32'(fifo_count), 0);
    check_val("mid_drop", 32'(drop_count), 0);
    start = pulses;
    repeat (6) tick();
    check_val("mid_no_pulse", 32'(pulses - start), 0);
    event_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_toggle();
    test_overflow();
    test_zero();
    test_bounds();
    test_back_to_back();
    test_mid_reset();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/event_ingress_fifo.md
EVENT_INGRESS_FIFO -- requirements
Module: event_ingress_fifo

Interface
- REQ-001 Parameter DATA_WIDTH, default 4: event value width; SHALL match the feature detector's DATA_WIDTH.
- REQ-002 Parameter ADDR_WIDTH, default 16: event address width, packed {x[15:8], y[7:0]}.
- REQ-003 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of two, at least 2.
- REQ-004 Parameter X_MAX, default 8'd127, and Y_MAX, default 8'd127: inclusive frame bounds.
- REQ-005 clk  input  1: single clock; all logic SHALL be clocked on its rising edge.
- REQ-006 rst_n  input  1: synchronous, active-low reset.
- REQ-007 s_event_valid  input  1: sensor event present this cycle.
- REQ-008 s_event_value  input  DATA_WIDTH: sensor event value.
- REQ-009 s_event_addr  input  ADDR_WIDTH: sensor event address.
- REQ-010 s_event_ready  output  1: FIFO can accept an event.
- REQ-011 event_req  input  1: level request from the feature detector.
- REQ-012 out_event_valid_0  output  1: one-cycle event pulse to the detector.
- REQ-013 out_event_value_0  output  DATA_WIDTH: issued event value.
- REQ-014 out_event_addr_0  output  ADDR_WIDTH: issued event address.
- REQ-015 fifo_count  output  $clog2(DEPTH)+1: current occupancy.
- REQ-016 drop_count  output  16: saturating count of lost or filtered events.

Function
- REQ-017 Push: s_event_valid && s_event_ready && accepted value SHALL write one entry at the clock edge; fifo_count reflects it next cycle.
- REQ-018 Value filter: an event with s_event_value == 0 SHALL NOT be written and SHALL increment drop_count.
- REQ-019 s_event_ready SHALL equal (fifo_count != DEPTH), registered-count based, with no same-cycle pop pass-through.
- REQ-020 Overflow: s_event_valid while s_event_ready is 0 SHALL discard the event and increment drop_count; the sensor is never stalled.
- REQ-021 drop_count SHALL saturate at 16'hFFFF and increment at most once per cycle.
- REQ-022 Issue FSM states: IDLE, ISSUE, WAIT_DROP.
- REQ-023 IDLE -> ISSUE when event_req == 1 and FIFO is non-empty; the head entry SHALL be popped on that edge.
- REQ-024 In ISSUE, out_event_valid_0 SHALL be 1 for exactly one cycle with the popped value and address; the next state is WAIT_DROP.
- REQ-025 WAIT_DROP -> IDLE when event_req == 0; at most one event SHALL be issued per event_req assertion.
- REQ-026 Latency: an event pushed at edge N with event_req already high and the FIFO otherwise empty SHALL appear on out_event_valid_0 in cycle N+2.
- REQ-027 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
- REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
- REQ-029 out_event_value_0 and out_event_addr_0 SHALL hold their last issued values when out_event_valid_0 is 0.

Reset
- REQ-030 While rst_n == 0 at a clock edge: FSM = IDLE, pointers = 0, fifo_count = 0, drop_count = 0, out_event_valid_0 = 0, out_event_value_0 = 0, out_event_addr_0 = 0.
- REQ-031 Reset mid-operation SHALL discard all buffered events and any pending issue without producing a partial pulse.

Configuration
- REQ-032 Macro EVT_BOUNDS_CHECK_EN: when defined, an event with x > X_MAX or y > Y_MAX SHALL be discarded and counted in drop_count.
- REQ-033 When EVT_BOUNDS_CHECK_EN is undefined, no bounds check SHALL exist, X_MAX and Y_MAX SHALL be unused, and all other behaviour SHALL be unchanged.

Structure
- REQ-034 A shared package evt_pkg SHALL hold the issue-FSM state enum, the packed event struct {value, addr}, and the X/Y field-slice constants.
- REQ-035 Storage SHALL be one sub-module, evt_sync_fifo (parameterised width and depth, registered count); the FSM and filters live in the top.

Verification
- REQ-036 Push {48,48} value 4'b1111, event_req held 1 -> single out_event_valid_0 pulse 2 cycles later, addr 16'h3030, value 4'hF.
- REQ-037 Push 3 events, event_req toggled 1/0 three times -> three pulses in push order; with event_req held 1, only one pulse.
- REQ-038 DEPTH+2 consecutive pushes, event_req = 0 -> s_event_ready drops after DEPTH, fifo_count = DEPTH, drop_count = 2.
- REQ-039 Push value 4'b0000 -> nothing queued, drop_count = 1.
- REQ-040 With EVT_BOUNDS_CHECK_EN defined, push {200,58} -> dropped, drop_count = 1; without the macro -> issued as 16'hC83A.
- REQ-041 Assert rst_n = 0 for one cycle with 5 entries queued and FSM in ISSUE -> all outputs and counters 0, no further pulses.
